// File: rtl/uart_tx_arbiter_if.sv
// Bundle between requesters, the arbiter and a UART transmitter.
// Launch and completion signals plus a debug view of the arbiter FSM.
interface uart_tx_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int D_WIDTH = 8
) ();
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: req[i] is a level held until done[i] (or abandoned); grant[i] pulses
  // once when the character is captured, and tx_transmit pulses with it.
  // tx_busy is the transmitter's acknowledge, which must rise within TIMEOUT cycles.
  // done[i] pulses once when tx_busy falls again.
  logic [N_REQ-1:0]         req;
  logic [N_REQ*D_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         done;
  logic                     tx_transmit;
  logic [D_WIDTH-1:0]       tx_data;
  logic                     tx_busy;
  logic                     active;
  logic [ID_W-1:0]          active_id;
  logic                     timeout_err;
  logic [1:0]               fsm_state;

  modport master (
    input  req, req_data, tx_busy,
    output grant, done, tx_transmit, tx_data, active, active_id, timeout_err, fsm_state
  );

  modport slave (
    output req, req_data, tx_busy,
    input  grant, done, tx_transmit, tx_data, active, active_id, timeout_err, fsm_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters,
// with a watchdog on the transmitter's busy acknowledge.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int D_WIDTH = 8,
  parameter int TIMEOUT = 8
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BUSY = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    active_id;
  logic [7:0]         timer;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               tx_transmit;
  logic [D_WIDTH-1:0] tx_data;
  logic               active;
  logic               timeout_err;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    cand;
  logic [D_WIDTH-1:0] win_data;

  // Search starts just past the last owner, so that owner ends up last in line.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    win_data = bus.req_data[int'(winner)*D_WIDTH +: D_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= ID_W'(N_REQ-1);
      timer       <= '0;
      grant       <= '0;
      done        <= '0;
      tx_transmit <= 1'b0;
      tx_data     <= '0;
      active      <= 1'b0;
      active_id   <= '0;
      timeout_err <= 1'b0;
    end else begin
      grant       <= '0;
      done        <= '0;
      tx_transmit <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !bus.tx_busy) begin
            tx_data     <= win_data;
            tx_transmit <= 1'b1;
            grant       <= ONE << winner;
            active_id   <= winner;
            active      <= 1'b1;
            timer       <= '0;
            state       <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == 8'(TIMEOUT-1)) begin
            timeout_err <= 1'b1;
            ptr         <= active_id;
            active      <= 1'b0;
            state       <= IDLE;
          end else if (timer != 8'hFF) begin
            timer <= timer + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            done   <= ONE << active_id;
            ptr    <= active_id;
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant;
  assign bus.done        = done;
  assign bus.tx_transmit = tx_transmit;
  assign bus.tx_data     = tx_data;
  assign bus.active      = active;
  assign bus.active_id   = active_id;
  assign bus.timeout_err = timeout_err;
  assign bus.fsm_state   = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: transmitter model, launch/done scoreboard,
// round-robin, timeout, external busy, reset abort and early withdrawal.
module tb_uart_tx_arbiter;
  localparam int N_REQ    = 4;
  localparam int D_WIDTH  = 8;
  localparam int TIMEOUT  = 8;
  localparam int ID_W     = $clog2(N_REQ);
  localparam int E_W      = ID_W + D_WIDTH;
  localparam int BUSY_LEN = 5;
  localparam int W_GRANT  = 0;
  localparam int W_DONE   = 1;
  localparam int W_TMO    = 2;
  localparam int W_WDONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .D_WIDTH(D_WIDTH)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .D_WIDTH(D_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int last_end_cyc = -100;
  int n_grant = 0;
  logic prev_busy = 1'b0;

  logic [E_W-1:0]     exp_q[$];
  logic [ID_W-1:0]    done_q[$];
  logic [D_WIDTH-1:0] data_v[N_REQ];

  logic       model_en = 1'b1;
  logic       ext_busy = 1'b0;
  logic       model_busy;
  int         busy_cnt;

  assign bus.tx_busy = model_busy | ext_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter: busy rises the cycle after a launch and stays up BUSY_LEN more cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_busy <= 1'b0;
    end else if (model_en && bus.tx_transmit) begin
      model_busy <= 1'b1;
      busy_cnt   <= BUSY_LEN;
    end
  end

  always @(negedge clk) begin
    logic [E_W-1:0]  e;
    logic [ID_W-1:0] d;
    if (!rst) begin
      if (bus.tx_transmit || bus.grant != '0) begin
        check("grant_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("grant_onehot", bus.grant, 32'd1 << e[E_W-1:D_WIDTH]);
          check("tx_transmit", bus.tx_transmit, 1);
          check("tx_data", bus.tx_data, e[D_WIDTH-1:0]);
          check("active_id", bus.active_id, e[E_W-1:D_WIDTH]);
        end
        check("launch_gap", (cyc - last_end_cyc) >= 1, 1);
        n_grant++;
      end
      if (bus.done != '0) begin
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check("done_onehot", bus.done, 32'd1 << d);
        end
        check("done_latency", cyc - fall_cyc, 1);
        last_end_cyc = cyc;
      end
      if (bus.timeout_err) last_end_cyc = cyc;
      if (prev_busy && !bus.tx_busy) fall_cyc = cyc;
      prev_busy = bus.tx_busy;
    end
  end

  task automatic load_data();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_data[i*D_WIDTH +: D_WIDTH] = data_v[i];
    end
  endtask

  task automatic push_exp(input int id, input bit with_done);
    exp_q.push_back({ID_W'(id), data_v[id]});
    if (with_done) done_q.push_back(ID_W'(id));
  endtask

  task automatic wait_for(input int kind, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (kind)
        W_GRANT: hit = |bus.grant;
        W_DONE:  hit = |bus.done;
        W_TMO:   hit = bus.timeout_err;
        W_WDONE: hit = (bus.fsm_state == 2'b10);
        default: hit = 1'b1;
      endcase
    end
    check(tag, hit, 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_grant"}, bus.grant, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_tx_transmit"}, bus.tx_transmit, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_active"}, bus.active, 0);
    check({tag, "_active_id"}, bus.active_id, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
    check({tag, "_state"}, bus.fsm_state, 0);
  endtask

  initial begin
    int g;
    int r;
    int snap;
    bus.req = '0;
    for (int i = 0; i < N_REQ; i++) data_v[i] = D_WIDTH'($urandom_range(0, 255));
    data_v[0] = 8'hA5;
    load_data();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Single requester
    push_exp(0, 1);
    bus.req = 4'b0001;
    wait_for(W_GRANT, 10, "s1_grant");
    check("s1_active", bus.active, 1);
    check("s1_state_wb", bus.fsm_state, 2'b01);
    wait_for(W_DONE, 20, "s1_done");
    bus.req = '0;
    @(negedge clk);
    check("s1_active_low", bus.active, 0);
    check("s1_data_hold", bus.tx_data, 8'hA5);
    check("s1_idle", bus.fsm_state, 2'b00);

    // Round-robin from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) data_v[i] = D_WIDTH'($urandom_range(0, 255));
    load_data();
    for (int i = 0; i < 5; i++) push_exp(i % N_REQ, 1);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_for(W_DONE, 30, "s2_done");
    bus.req = '0;
    check("s2_queue_empty", exp_q.size(), 0);

    // Timeout, then arbitration resumes after requester 2
    model_en = 1'b0;
    push_exp(2, 0);
    bus.req = 4'b0100;
    wait_for(W_GRANT, 10, "s3_grant");
    g = cyc;
    wait_for(W_TMO, 20, "s3_timeout");
    check("s3_timeout_delay", cyc - g, TIMEOUT);
    check("s3_no_done", bus.done, 0);
    check("s3_active_low", bus.active, 0);
    model_en = 1'b1;
    push_exp(3, 1);
    bus.req = 4'b1111;
    wait_for(W_DONE, 30, "s3_done3");
    bus.req = '0;

    // External busy blocks the launch
    ext_busy = 1'b1;
    bus.req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("s4_no_launch", bus.grant, 0);
    end
    push_exp(1, 1);
    ext_busy = 1'b0;
    r = cyc;
    wait_for(W_GRANT, 10, "s4_grant");
    check("s4_grant_delay", cyc - r, 1);
    wait_for(W_DONE, 20, "s4_done");
    bus.req = '0;

    // Reset while waiting for done
    push_exp(3, 0);
    bus.req = 4'b1001;
    wait_for(W_GRANT, 10, "s5_grant");
    wait_for(W_WDONE, 10, "s5_wait_done");
    rst = 1'b1;
    #1;
    check_cleared("s5_async");
    @(negedge clk);
    @(negedge clk);
    push_exp(0, 1);
    rst = 1'b0;
    wait_for(W_DONE, 30, "s5_done0");
    bus.req = '0;

    // One-cycle request while another transfer is in WAIT_DONE
    push_exp(0, 1);
    bus.req = 4'b0001;
    wait_for(W_GRANT, 10, "s6_grant");
    bus.req = '0;
    wait_for(W_WDONE, 10, "s6_wait_done");
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = '0;
    wait_for(W_DONE, 20, "s6_done");
    snap = n_grant;
    repeat (10) @(negedge clk);
    check("s6_no_grant", n_grant - snap, 0);

    check("final_exp_q", exp_q.size(), 0);
    check("final_done_q", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
